lsu_align: RTL
==============

# lsu_align

Load/store alignment stage between the core's execute stage and one port of the byte-addressable 32-bit data RAM. Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word address, lane-replicated write data and byte mask. Extracts and sign- or zero-extends returned read data. Holds at most one outstanding access and buffers the response, because the RAM port cannot be back-pressured.

## Interface

- `ADDR_W`, 15: byte-address width of the RAM port, equal to log2(depth)+2.
- `clk`  in  1  clock
- `rstf`  in  1  reset, asynchronous, active-low
- `t_req_valid`  in  1  request valid
- `t_req_ready`  out  1  request accepted this cycle
- `t_req_we`  in  1  1 = store, 0 = load
- `t_req_funct3`  in  3  RISC-V funct3
- `t_req_addr`  in  32  byte address
- `t_req_wdata`  in  32  store data, LSB-aligned
- `i_rsp_valid`  out  1  response valid
- `i_rsp_ready`  in  1  response consumed
- `i_rsp_data`  out  32  extended load data; 0 for stores and errors
- `i_rsp_err`  out  1  access rejected
- `i_mem_valid`  out  1  RAM request valid
- `i_mem_ready`  in  1  RAM request ready
- `i_mem_we`  out  1  RAM write enable
- `i_mem_addr`  out  ADDR_W  byte address, `t_req_addr[ADDR_W-1:0]`
- `i_mem_data`  out  [3:0][7:0]  lane data
- `i_mem_mask`  out  4  byte-lane enables
- `t_mem_valid`  in  1  RAM read data valid
- `t_mem_data`  in  [3:0][7:0]  RAM read data

## Operation

The FSM has three states: IDLE, RD_WAIT, RSP.

**IDLE**
- `t_req_ready` = `i_mem_ready` | reject.
- `i_mem_valid` = `t_req_valid` & ~reject. The RAM request is driven combinationally from `t_req_*`.

**Reject conditions**
- Illegal funct3: loads with 011/110/111, stores with funct3 ≥ 011.
- Misalignment, only with the configuration macro (see Configuration).

**Acceptance in IDLE**
- Reject → RSP with err = 1, data = 0. No RAM access.
- Store → RSP with err = 0, data = 0. `i_mem_we` = 1.
  - SB: byte replicated to all lanes, mask = 1 << addr[1:0].
  - SH: halfword in lanes {1,0} and {3,2}, mask 0011 if addr[1] = 0, else 1100.
  - SW: mask 1111.
- Load → RD_WAIT. `i_mem_we` = 0, mask = 0000. Capture funct3 and addr[1:0].

**RD_WAIT**
- `t_req_ready` = 0.
- On `t_mem_valid`, register the response and go to RSP.
  - LB/LBU: byte at lane addr[1:0].
  - LH/LHU: halfword at lanes {addr[1],1} and {addr[1],0}.
  - LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.

**RSP**
- `i_rsp_valid` = 1. `i_rsp_data` and `i_rsp_err` are held stable.
- On `i_rsp_ready` → IDLE. The next request is not accepted in the same cycle.

**Other rules**
- `t_mem_valid` outside RD_WAIT is ignored and dropped.
- Address bits [31:ADDR_W] are ignored.

## Timing

- Reset values: state IDLE; `i_rsp_valid` = 0, `i_rsp_data` = 0, `i_rsp_err` = 0. Combinational outputs follow from IDLE.
- Load accepted at edge N → RAM returns data in cycle N+1 → `i_rsp_valid` high in cycle N+2.
- Store or reject accepted at edge N → `i_rsp_valid` high in cycle N+1.
- Maximum throughput: one store per 2 cycles, one load per 3 cycles.
- Reset asserted mid-access: the FSM returns to IDLE immediately. Read data returning after reset release is dropped. A RAM write already issued is not undone.
- `i_mem_ready` low in IDLE: no acceptance and `t_req_ready` = 0, except rejects, which are accepted regardless.

## Configuration

- `LSU_MISALIGN_TRAP_EN` defined:
  - Halfword with addr[0] = 1 is rejected.
  - Word with addr[1:0] ≠ 00 is rejected.
  - Rejected accesses return err = 1 and perform no RAM access.
- Undefined:
  - Misaligned halfword is treated as addr[0] = 0.
  - Misaligned word is treated as addr[1:0] = 00.
  - The low bits are still passed on `i_mem_addr`. No error is reported.

## Test plan

- **SB:** addr 0x00000006, wdata 0x000000A5 → `i_mem_data` = A5A5A5A5, mask 0100, we = 1. Response in N+1: data 0, err 0.
- **Sign/zero extension:** RAM word 0x80FF7F01 at addr 0x10.
  - LB @0x11 → 0x0000007F.
  - LB @0x13 → 0xFFFFFF80.
  - LHU @0x12 → 0x000080FF.
  - LH @0x12 → 0xFFFF80FF.
  - Each response valid in N+2.
- **Backpressure:** `i_rsp_ready` held low 5 cycles after a LW response. Data stays stable, `t_req_ready` = 0, a new `t_req_valid` is not accepted. Ready high → IDLE on the next cycle.
- **Illegal funct3:** load funct3 = 111 → `i_mem_valid` = 0, err = 1, data = 0 in N+1.
- **Misaligned LW @0x102:**
  - With `LSU_MISALIGN_TRAP_EN`: err = 1, no RAM access.
  - Without: returns the word at 0x100, err = 0.
- **Reset in RD_WAIT:** `rstf` low for 1 cycle in RD_WAIT, followed by a spurious `t_mem_valid` → `i_rsp_valid` stays 0 and state is IDLE.

Source files
------------

// File: rtl/lsu_align_if.sv
// lsu_align_if -- bundle of every request, response and RAM-port signal of
// the lsu_align load/store alignment stage.
//
// Handshake semantics (all three channels): a transfer happens on a rising
// clock edge where both valid and ready are high. The RAM read-data return
// (t_mem_valid/t_mem_data) has no ready; it is a one-cycle pulse that the
// stage must take when offered.
//
// Modports:
//   slave  : the lsu_align side (drives t_req_ready, i_rsp_*, i_mem_*)
//   master : the environment side (core + RAM)
//
// Parameter ADDR_W: byte-address width of the RAM port (log2(depth)+2).
interface lsu_align_if #(
  parameter int ADDR_W = 15
);
  // core request
  logic                t_req_valid;
  logic                t_req_ready;
  logic                t_req_we;
  logic [2:0]          t_req_funct3;
  logic [31:0]         t_req_addr;
  logic [31:0]         t_req_wdata;
  // core response
  logic                i_rsp_valid;
  logic                i_rsp_ready;
  logic [31:0]         i_rsp_data;
  logic                i_rsp_err;
  // RAM request
  logic                i_mem_valid;
  logic                i_mem_ready;
  logic                i_mem_we;
  logic [ADDR_W-1:0]   i_mem_addr;
  logic [3:0][7:0]     i_mem_data;
  logic [3:0]          i_mem_mask;
  // RAM read return
  logic                t_mem_valid;
  logic [3:0][7:0]     t_mem_data;

  modport slave (
    input  t_req_valid, t_req_we, t_req_funct3, t_req_addr, t_req_wdata,
    output t_req_ready,
    output i_rsp_valid, i_rsp_data, i_rsp_err,
    input  i_rsp_ready,
    output i_mem_valid, i_mem_we, i_mem_addr, i_mem_data, i_mem_mask,
    input  i_mem_ready,
    input  t_mem_valid, t_mem_data
  );

  modport master (
    output t_req_valid, t_req_we, t_req_funct3, t_req_addr, t_req_wdata,
    input  t_req_ready,
    input  i_rsp_valid, i_rsp_data, i_rsp_err,
    output i_rsp_ready,
    input  i_mem_valid, i_mem_we, i_mem_addr, i_mem_data, i_mem_mask,
    output i_mem_ready,
    output t_mem_valid, t_mem_data
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align -- load/store alignment stage between execute and one port of a
// byte-addressable 32-bit data RAM. Turns LB/LH/LW/LBU/LHU/SB/SH/SW into a
// RAM access with lane-replicated write data and byte mask, and extends the
// returned read data. At most one access is outstanding; the response is
// buffered because the RAM return cannot be stalled.
//
// Ports:
//   clk        clock
//   rstf       asynchronous active-low reset
//   bus        lsu_align_if.slave (request, response, RAM port)
//   dbg_state  current FSM state: 0 = IDLE, 1 = RD_WAIT, 2 = RSP
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned
// halfword/word accesses with err = 1. Without it, the low address bits are
// ignored for lane selection (but still passed on i_mem_addr).
module lsu_align #(
  parameter int ADDR_W = 15
) (
  input  logic          clk,
  input  logic          rstf,
  lsu_align_if.slave    bus,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic [31:0] rsp_data, rsp_data_nxt;
  logic        rsp_err, rsp_err_nxt;
  logic        rsp_load;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic        ld_cap;

  logic        illegal, misalign, reject;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request decode: reject is evaluated from the raw request so that
  // rejects can be accepted even while the RAM port is not ready.
  always_comb begin
    if (bus.t_req_we) begin
      illegal = (bus.t_req_funct3 > 3'd2);
    end else begin
      illegal = (bus.t_req_funct3 == 3'b011) || (bus.t_req_funct3[2:1] == 2'b11);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((bus.t_req_funct3[1:0] == 2'b01) && bus.t_req_addr[0]) ||
               ((bus.t_req_funct3[1:0] == 2'b10) && (bus.t_req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    reject = illegal | misalign;
  end

  // Store lane placement: data is replicated so the mask alone picks lanes.
  always_comb begin
    st_data = bus.t_req_wdata;
    st_mask = 4'b1111;
    case (bus.t_req_funct3[1:0])
      2'b00: begin
        st_data = {4{bus.t_req_wdata[7:0]}};
        st_mask = 4'b0001 << bus.t_req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{bus.t_req_wdata[15:0]}};
        st_mask = bus.t_req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load extraction from the captured offset and funct3.
  always_comb begin
    ld_byte = bus.t_mem_data[ld_off];
    ld_half = ld_off[1] ? {bus.t_mem_data[3], bus.t_mem_data[2]}
                        : {bus.t_mem_data[1], bus.t_mem_data[0]};
    case (ld_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus.t_mem_data;
    endcase
  end

  // RAM request fields follow the core request; only valid is gated.
  assign bus.i_mem_we   = bus.t_req_we;
  assign bus.i_mem_addr = bus.t_req_addr[ADDR_W-1:0];
  assign bus.i_mem_data = st_data;
  assign bus.i_mem_mask = bus.t_req_we ? st_mask : 4'b0000;

  assign bus.i_rsp_valid = (state == RSP);
  assign bus.i_rsp_data  = rsp_data;
  assign bus.i_rsp_err   = rsp_err;
  assign dbg_state       = state;

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.t_req_ready = 1'b0;
    bus.i_mem_valid = 1'b0;
    rsp_load        = 1'b0;
    rsp_data_nxt    = 32'd0;
    rsp_err_nxt     = 1'b0;
    ld_cap          = 1'b0;
    case (state)
      IDLE: begin
        bus.t_req_ready = bus.i_mem_ready | reject;
        bus.i_mem_valid = bus.t_req_valid & ~reject;
        if (bus.t_req_valid && bus.t_req_ready) begin
          if (reject) begin
            state_nxt   = RSP;
            rsp_load    = 1'b1;
            rsp_err_nxt = 1'b1;
          end else if (bus.t_req_we) begin
            state_nxt = RSP;
            rsp_load  = 1'b1;
          end else begin
            state_nxt = RD_WAIT;
            ld_cap    = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (bus.t_mem_valid) begin
          state_nxt    = RSP;
          rsp_load     = 1'b1;
          rsp_data_nxt = ld_ext;
        end
      end
      RSP: begin
        if (bus.i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
      ld_funct3 <= 3'd0;
      ld_off    <= 2'd0;
    end else begin
      if (ld_cap) begin
        ld_funct3 <= bus.t_req_funct3;
        ld_off    <= bus.t_req_addr[1:0];
      end
      if (rsp_load) begin
        rsp_data <= rsp_data_nxt;
        rsp_err  <= rsp_err_nxt;
      end
    end
  end

endmodule
